// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter: default bus widths and the
// arbiter state encoding.
package bus_pkg;
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_HANDOFF = 2'd2
  } arb_state_t;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_j;

  // Scan from the lowest priority down so the last hit is the highest priority.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (i_req[w_j]) begin
        o_idx = IW'(w_j);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared system bus: registered one-hot grant,
// owner mux onto the slave side, forced release after MAX_HOLD grant cycles.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int MAX_HOLD    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_breq,
  output logic [NUM_MASTERS-1:0]        m_bgrant,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]        m_mode,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  output logic [NUM_MASTERS-1:0]        m_sl_valid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic                          s_mode,
  output logic                          s_valid,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_done,
  output logic [$clog2(NUM_MASTERS)-1:0] owner_id,
  output logic                          bus_busy,
  output logic                          hold_timeout,
  output logic [1:0]                    o_dbg_state
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_HOLD);

  localparam logic [1:0] S_IDLE    = ARB_IDLE;
  localparam logic [1:0] S_GRANT   = ARB_GRANT;
  localparam logic [1:0] S_HANDOFF = ARB_HANDOFF;

  logic [1:0]             r_state;
  logic [NUM_MASTERS-1:0] r_bgrant;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_ptr;
  logic [CW-1:0]          r_hold;
  logic                   r_tmo;

  logic [IW-1:0]          w_pick;
  logic                   w_any;
  logic                   w_granted;
  logic                   w_owner_req;
  logic                   w_limit;
  logic                   w_release;
  logic [IW-1:0]          w_next_ptr;

  rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_rr_pick (
    .i_req (m_breq),
    .i_ptr (r_ptr),
    .o_idx (w_pick),
    .o_any (w_any)
  );

  assign w_granted   = (r_state == S_GRANT);
  assign w_owner_req = m_breq[r_owner];
  assign w_limit     = (r_hold == CW'(MAX_HOLD - 1));
  assign w_release   = w_granted && (!w_owner_req || w_limit);
  assign w_next_ptr  = (r_owner == IW'(NUM_MASTERS - 1)) ? '0 : r_owner + IW'(1);

  // Every release, voluntary or forced, passes through one HANDOFF cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_bgrant <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_tmo    <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state  <= S_GRANT;
            r_bgrant <= NUM_MASTERS'(1) << w_pick;
            r_owner  <= w_pick;
            r_hold   <= '0;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state  <= S_HANDOFF;
            r_bgrant <= '0;
            r_ptr    <= w_next_ptr;
            r_tmo    <= w_owner_req;
          end else begin
            r_hold <= r_hold + CW'(1);
          end
        end
        S_HANDOFF: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // s_valid qualifies the owner's transfer; s_done completes it and is only
  // routed back to the owner while the grant is live.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_mode  = 1'b0;
    s_valid = 1'b0;
    if (w_granted) begin
      s_addr  = m_addr[int'(r_owner)*ADDR_W +: ADDR_W];
      s_wdata = m_wdata[int'(r_owner)*DATA_W +: DATA_W];
      s_mode  = m_mode[r_owner];
      s_valid = m_valid[r_owner];
    end
  end

  assign m_sl_valid   = (s_done && w_granted) ? r_bgrant : '0;
  assign m_rdata      = s_rdata;
  assign m_bgrant     = r_bgrant;
  assign owner_id     = r_owner;
  assign bus_busy     = w_granted;
  assign hold_timeout = r_tmo;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// checked against a cycle-level ownership model and a grant/timeout scoreboard.
module tb_bus_arbiter;

  localparam int NM = 3;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MAX_HOLD = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NM-1:0]        m_breq = '1;
  logic [NM-1:0]        m_bgrant;
  logic [NM*AW-1:0]     m_addr = '0;
  logic [NM*DW-1:0]     m_wdata = '0;
  logic [NM-1:0]        m_mode = '0;
  logic [NM-1:0]        m_valid = '0;
  logic [NM-1:0]        m_sl_valid;
  logic [DW-1:0]        m_rdata;
  logic [AW-1:0]        s_addr;
  logic [DW-1:0]        s_wdata;
  logic                 s_mode;
  logic                 s_valid;
  logic [DW-1:0]        s_rdata = '0;
  logic                 s_done = 1'b0;
  logic [1:0]           owner_id;
  logic                 bus_busy;
  logic                 hold_timeout;
  logic [1:0]           dbg_state;

  bus_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_HOLD    (MAX_HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_breq       (m_breq),
    .m_bgrant     (m_bgrant),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_mode       (m_mode),
    .m_valid      (m_valid),
    .m_sl_valid   (m_sl_valid),
    .m_rdata      (m_rdata),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_mode       (s_mode),
    .s_valid      (s_valid),
    .s_rdata      (s_rdata),
    .s_done       (s_done),
    .owner_id     (owner_id),
    .bus_busy     (bus_busy),
    .hold_timeout (hold_timeout),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [23:0] exp_q[$];   // {owner[7:0], grant start cycle[15:0]}
  logic [15:0] tmo_q[$];   // cycle of expected hold_timeout pulse
  int gnt_log[$];
  int gnt_cyc_log[$];
  int tmo_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Ownership view: md_owner is the master holding the bus (-1 when free),
  // md_held counts grant cycles so far, md_gap marks the dead cycle after a release.
  int md_owner = -1;
  int md_held = 0;
  int md_ptr = 0;
  int md_last = 0;
  bit md_gap = 1'b0;
  bit md_tmo = 1'b0;

  always @(posedge clk) begin : model
    int j;
    cyc++;
    md_tmo = 1'b0;
    if (!rst_n) begin
      md_owner = -1;
      md_gap   = 1'b0;
      md_ptr   = 0;
      md_last  = 0;
      md_held  = 0;
    end else if (md_owner >= 0) begin
      if (!m_breq[md_owner] || md_held == MAX_HOLD) begin
        md_tmo = m_breq[md_owner];
        if (md_tmo) tmo_q.push_back(16'(cyc));
        md_ptr   = (md_owner + 1) % NM;
        md_owner = -1;
        md_gap   = 1'b1;
      end else begin
        md_held++;
      end
    end else if (md_gap) begin
      md_gap = 1'b0;
    end else if (m_breq != '0) begin
      for (int k = 0; k < NM; k++) begin
        j = (md_ptr + k) % NM;
        if (md_owner < 0 && m_breq[j]) md_owner = j;
      end
      md_last = md_owner;
      md_held = 1;
      exp_q.push_back({8'(md_owner), 16'(cyc)});
    end
  end

  // ---------------- monitor ----------------
  logic [NM-1:0] prev_gnt = '0;

  always @(negedge clk) begin : monitor
    logic [NM-1:0] e_gnt;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_mode;
    logic          e_valid;
    logic [23:0]   item;
    logic [15:0]   titem;
    if (cyc > 0) begin
      e_gnt   = '0;
      e_addr  = '0;
      e_wdata = '0;
      e_mode  = 1'b0;
      e_valid = 1'b0;
      if (md_owner >= 0) begin
        e_gnt   = NM'(1) << md_owner;
        e_addr  = m_addr[md_owner*AW +: AW];
        e_wdata = m_wdata[md_owner*DW +: DW];
        e_mode  = m_mode[md_owner];
        e_valid = m_valid[md_owner];
      end
      chk("bgrant", 32'(m_bgrant), 32'(e_gnt));
      chk("bus_busy", 32'(bus_busy), 32'(md_owner >= 0));
      chk("owner_id", 32'(owner_id), 32'(md_last));
      chk("hold_timeout", 32'(hold_timeout), 32'(md_tmo));
      chk("s_valid", 32'(s_valid), 32'(e_valid));
      chk("s_addr", 32'(s_addr), 32'(e_addr));
      chk("s_wdata", 32'(s_wdata), 32'(e_wdata));
      chk("s_mode", 32'(s_mode), 32'(e_mode));
      chk("m_sl_valid", 32'(m_sl_valid), 32'(s_done ? e_gnt : '0));
      chk("m_rdata", 32'(m_rdata), 32'(s_rdata));

      if (m_bgrant != '0 && prev_gnt == '0) begin
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", 32'(m_bgrant), 32'd0);
        end else begin
          item = exp_q.pop_front();
          chk("gnt_owner", 32'(owner_id), 32'(item[23:16]));
          chk("gnt_cycle", 32'(cyc[15:0]), 32'(item[15:0]));
        end
        gnt_log.push_back(int'(owner_id));
        gnt_cyc_log.push_back(cyc);
      end
      if (hold_timeout) begin
        tmo_seen++;
        if (tmo_q.size() == 0) begin
          chk("tmo_unexpected", 32'd1, 32'd0);
        end else begin
          titem = tmo_q.pop_front();
          chk("tmo_cycle", 32'(cyc[15:0]), 32'(titem));
        end
      end
      prev_gnt = m_bgrant;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NM; i++) begin
      m_addr[i*AW +: AW]  = AW'($urandom);
      m_wdata[i*DW +: DW] = DW'($urandom);
    end
    m_mode  = NM'($urandom);
    m_valid = NM'($urandom);
    s_rdata = DW'($urandom);
    s_done  = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input logic [NM-1:0] req);
    rst_n  = 1'b0;
    m_breq = req;
    tick();
    tick();
    rst_n  = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int base;
  int t0;
  logic [NM-1:0] b;

  initial begin
    // Reset with every master requesting: nothing may be granted.
    do_reset('1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_bgrant", 32'(m_bgrant), 32'd0);
    chk("rst_busy", 32'(bus_busy), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_tmo", 32'(hold_timeout), 32'd0);
    rst_n  = 1'b1;
    m_breq = '0;
    s_done = 1'b0;
    tick();
    tick();

    // Single request from master 1.
    rand_data();
    m_valid = 3'b010;
    m_breq  = 3'b010;
    tick();
    @(negedge clk);
    chk("single_bgrant", 32'(m_bgrant), 32'b010);
    chk("single_owner", 32'(owner_id), 32'd1);
    chk("single_s_addr", 32'(s_addr), 32'(m_addr[1*AW +: AW]));
    chk("single_s_valid", 32'(s_valid), 32'd1);
    tick();
    m_breq = '0;
    tick();
    tick();

    // Round-robin: everyone requests, owner drops for one cycle after 3 grant cycles.
    do_reset('1);
    base = gnt_log.size();
    for (int t = 0; t < 80 && gnt_log.size() < base + 4; t++) begin
      rand_data();
      b = '1;
      if (md_owner >= 0 && md_held == 3) b[md_owner] = 1'b0;
      m_breq = b;
      tick();
    end
    chk("rr_count", 32'(gnt_log.size() - base), 32'd4);
    if (gnt_log.size() >= base + 4) begin
      chk("rr_order0", 32'(gnt_log[base]), 32'd0);
      chk("rr_order1", 32'(gnt_log[base+1]), 32'd1);
      chk("rr_order2", 32'(gnt_log[base+2]), 32'd2);
      chk("rr_order3", 32'(gnt_log[base+3]), 32'd0);
      chk("rr_spacing", 32'(gnt_cyc_log[base+1] - gnt_cyc_log[base]), 32'd5);
    end
    m_breq = '0;
    tick();
    tick();

    // Completion routing to owner 2, then ignored during HANDOFF.
    do_reset('0);
    m_breq = 3'b100;
    s_done = 1'b1;
    tick();
    @(negedge clk);
    chk("cpl_owner", 32'(owner_id), 32'd2);
    chk("cpl_sl_valid", 32'(m_sl_valid), 32'b100);
    m_breq = '0;
    tick();
    @(negedge clk);
    chk("cpl_handoff_sl_valid", 32'(m_sl_valid), 32'd0);
    chk("cpl_handoff_busy", 32'(bus_busy), 32'd0);
    s_done = 1'b0;
    tick();

    // Hold timeout: master 0 never lets go, master 1 waits.
    do_reset('0);
    t0 = tmo_seen;
    base = gnt_log.size();
    m_breq = 3'b011;
    for (int t = 0; t < 40 && gnt_log.size() < base + 2; t++) begin
      tick();
    end
    chk("tmo_grants", 32'(gnt_log.size() - base), 32'd2);
    if (gnt_log.size() >= base + 2) begin
      chk("tmo_first", 32'(gnt_log[base]), 32'd0);
      chk("tmo_second", 32'(gnt_log[base+1]), 32'd1);
      chk("tmo_spacing", 32'(gnt_cyc_log[base+1] - gnt_cyc_log[base]), 32'd6);
    end
    chk("tmo_pulses", 32'(tmo_seen - t0), 32'd1);
    m_breq = '0;
    tick();
    tick();

    // Reset in the middle of master 1's grant.
    do_reset('0);
    m_breq = 3'b010;
    tick();
    tick();
    rst_n  = 1'b0;
    m_breq = '1;
    tick();
    @(negedge clk);
    chk("midrst_bgrant", 32'(m_bgrant), 32'd0);
    chk("midrst_owner", 32'(owner_id), 32'd0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_regrant", 32'(m_bgrant), 32'b001);
    m_breq = '0;
    tick();
    tick();

    // Random traffic with sticky requests and rare resets.
    for (int t = 0; t < 600; t++) begin
      rand_data();
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, 3) == 0) m_breq[i] = ~m_breq[i];
      end
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n  = 1'b1;
    m_breq = '0;
    for (int t = 0; t < 8; t++) tick();
    @(negedge clk);
    chk("end_gnt_q_empty", 32'(exp_q.size()), 32'd0);
    chk("end_tmo_q_empty", 32'(tmo_q.size()), 32'd0);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
